// File: rtl/bilinear_seq_ctrl.sv
// Bilinear rescaling sequencer: walks the output image in raster order, fetches four input
// neighbours per pixel and writes the blend. Define BILSEQ_ROUND_EN to round half-up.
module bilinear_seq_ctrl #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_sys,
  input  logic          rst_sys_n,
  input  logic          start,
  input  logic [15:0]   cfg_in_w,
  input  logic [15:0]   cfg_in_h,
  input  logic [15:0]   cfg_scale_q88,
  output logic [AW-1:0] in_mem_raddr,
  input  logic [7:0]    in_mem_rdata,
  output logic [AW-1:0] out_mem_waddr,
  output logic [7:0]    out_mem_wdata,
  output logic          out_mem_we,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [15:0]   out_w,
  output logic [15:0]   out_h
);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, FETCH, INTERP, WRITE, FIN, ERR} state_e;

`ifdef BILSEQ_ROUND_EN
  localparam logic [25:0] RND = 26'd32768;
`else
  localparam logic [25:0] RND = 26'd0;
`endif
  localparam logic [32:0] AREA_MAX = 33'd1 << AW;

  state_e        state_q;
  logic          start_d_q, busy_q, done_q, err_q, we_q, last_q;
  logic [AW-1:0] raddr_q, waddr_q, oidx_q;
  logic [7:0]    wdata_q, p00_q, p01_q, p10_q, p11_q;
  logic [15:0]   inw_q, inh_q, scale_q, ow_q, oh_q, ox_q, oy_q;
  logic [31:0]   sx_q, sy_q;
  logic [15:0]   rem_q;
  logic [16:0]   dvd_q, quo_q;
  logic [4:0]    dcnt_q;
  logic [2:0]    fcnt_q;

  logic [31:0]   ow_full, oh_full, in_area, out_area;
  logic          cfg_bad;
  logic [16:0]   div_sh, div_sub;
  logic          div_ge;
  logic [15:0]   rem_d;
  logic [23:0]   x0_raw, y0_raw;
  logic [15:0]   inw_m1, inh_m1, x0, x1, y0, y1;
  logic [31:0]   row0, row1;
  logic [AW-1:0] a00, a01, a10, a11;
  logic [8:0]    wfx, wfy;
  logic [16:0]   top, bot;
  logic [25:0]   acc;
  logic [9:0]    pix_raw;
  logic [7:0]    pix;
  logic [31:0]   sx_inc, sy_inc;

  always_comb begin
    ow_full  = ({16'd0, inw_q} * {16'd0, scale_q}) >> 8;
    oh_full  = ({16'd0, inh_q} * {16'd0, scale_q}) >> 8;
    in_area  = {16'd0, inw_q} * {16'd0, inh_q};
    out_area = {16'd0, ow_full[15:0]} * {16'd0, oh_full[15:0]};
    cfg_bad  = (inw_q == 16'd0) || (inh_q == 16'd0) ||
               (ow_full == 32'd0) || (oh_full == 32'd0) ||
               (ow_full > 32'd65535) || (oh_full > 32'd65535) ||
               ({1'b0, in_area} > AREA_MAX) || ({1'b0, out_area} > AREA_MAX);

    // One restoring step of 65536 / scale per DIV cycle; the dividend bits shift out MSB first.
    div_sh  = {rem_q, dvd_q[16]};
    div_ge  = div_sh >= {1'b0, scale_q};
    div_sub = div_sh - {1'b0, scale_q};
    rem_d   = 16'(div_ge ? div_sub : div_sh);

    inw_m1 = inw_q - 16'd1;
    inh_m1 = inh_q - 16'd1;
    x0_raw = sx_q[31:8];
    y0_raw = sy_q[31:8];
    if (x0_raw >= {8'd0, inw_m1}) begin
      x0 = inw_m1;
      x1 = inw_m1;
    end else begin
      x0 = x0_raw[15:0];
      x1 = x0_raw[15:0] + 16'd1;
    end
    if (y0_raw >= {8'd0, inh_m1}) begin
      y0 = inh_m1;
      y1 = inh_m1;
    end else begin
      y0 = y0_raw[15:0];
      y1 = y0_raw[15:0] + 16'd1;
    end
    row0 = {16'd0, y0} * {16'd0, inw_q};
    row1 = {16'd0, y1} * {16'd0, inw_q};
    a00  = AW'(row0 + {16'd0, x0});
    a01  = AW'(row0 + {16'd0, x1});
    a10  = AW'(row1 + {16'd0, x0});
    a11  = AW'(row1 + {16'd0, x1});

    wfx     = 9'd256 - {1'b0, sx_q[7:0]};
    wfy     = 9'd256 - {1'b0, sy_q[7:0]};
    top     = 17'(p00_q) * 17'(wfx) + 17'(p01_q) * 17'(sx_q[7:0]);
    bot     = 17'(p10_q) * 17'(wfx) + 17'(p11_q) * 17'(sx_q[7:0]);
    acc     = 26'(top) * 26'(wfy) + 26'(bot) * 26'(sy_q[7:0]) + RND;
    pix_raw = 10'(acc >> 16);
    pix     = (pix_raw > 10'd255) ? 8'hFF : pix_raw[7:0];

    sx_inc = sx_q + {15'd0, quo_q};
    sy_inc = sy_q + {15'd0, quo_q};
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      oidx_q    <= '0;
      wdata_q   <= '0;
      p00_q     <= '0;
      p01_q     <= '0;
      p10_q     <= '0;
      p11_q     <= '0;
      inw_q     <= '0;
      inh_q     <= '0;
      scale_q   <= '0;
      ow_q      <= '0;
      oh_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      quo_q     <= '0;
      dcnt_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      start_d_q <= start;
      we_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !start_d_q) begin
            inw_q   <= cfg_in_w;
            inh_q   <= cfg_in_h;
            scale_q <= cfg_scale_q88;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          ow_q    <= ow_full[15:0];
          oh_q    <= oh_full[15:0];
          ox_q    <= '0;
          oy_q    <= '0;
          sx_q    <= '0;
          sy_q    <= '0;
          oidx_q  <= '0;
          last_q  <= 1'b0;
          rem_q   <= '0;
          dvd_q   <= 17'h10000;
          quo_q   <= '0;
          dcnt_q  <= '0;
          state_q <= cfg_bad ? ERR : DIV;
        end
        DIV: begin
          rem_q  <= rem_d;
          quo_q  <= {quo_q[15:0], div_ge};
          dvd_q  <= dvd_q << 1;
          dcnt_q <= dcnt_q + 5'd1;
          if (dcnt_q == 5'd16) begin
            raddr_q <= a00;
            fcnt_q  <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // Address k is on the bus during cycle k; its data lands one cycle later.
          fcnt_q <= fcnt_q + 3'd1;
          case (fcnt_q)
            3'd0: raddr_q <= a01;
            3'd1: begin p00_q <= in_mem_rdata; raddr_q <= a10; end
            3'd2: begin p01_q <= in_mem_rdata; raddr_q <= a11; end
            3'd3: p10_q <= in_mem_rdata;
            default: begin
              p11_q   <= in_mem_rdata;
              fcnt_q  <= '0;
              state_q <= INTERP;
            end
          endcase
        end
        INTERP: begin
          wdata_q <= pix;
          waddr_q <= oidx_q;
          we_q    <= 1'b1;
          oidx_q  <= oidx_q + AW'(1);
          // Accumulators advance here so WRITE can already present the next pixel's first address.
          if (ox_q == ow_q - 16'd1) begin
            ox_q   <= '0;
            sx_q   <= '0;
            oy_q   <= oy_q + 16'd1;
            sy_q   <= sy_inc;
            last_q <= (oy_q == oh_q - 16'd1);
          end else begin
            ox_q   <= ox_q + 16'd1;
            sx_q   <= sx_inc;
            last_q <= 1'b0;
          end
          state_q <= WRITE;
        end
        WRITE: begin
          if (last_q) begin
            state_q <= FIN;
          end else begin
            raddr_q <= a00;
            fcnt_q  <= '0;
            state_q <= FETCH;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        ERR: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_mem_raddr  = raddr_q;
  assign out_mem_waddr = waddr_q;
  assign out_mem_wdata = wdata_q;
  assign out_mem_we    = we_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = err_q;
  assign out_w         = ow_q;
  assign out_h         = oh_q;

endmodule

// File: tb/tb_bilinear_seq_ctrl.sv
// Self-checking bench for bilinear_seq_ctrl: table vectors, corner sequences and random jobs
// compared against an arithmetic reference of the scaler.
module tb_bilinear_seq_ctrl;

  localparam int AW    = 10;
  localparam int MEMSZ = 1 << AW;
`ifdef BILSEQ_ROUND_EN
  localparam longint RND      = 32768;
  localparam int     RND_OUT1 = 1;
`else
  localparam longint RND      = 0;
  localparam int     RND_OUT1 = 0;
`endif

  logic          clk_sys = 1'b0;
  logic          rst_sys_n;
  logic          start;
  logic [15:0]   cfg_in_w, cfg_in_h, cfg_scale_q88;
  logic [AW-1:0] in_mem_raddr, out_mem_waddr;
  logic [7:0]    in_mem_rdata, out_mem_wdata;
  logic          out_mem_we, busy, done, cfg_err;
  logic [15:0]   out_w, out_h;

  logic [7:0] in_img [MEMSZ];
  int         wr_addr[$];
  int         wr_data[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       busy_seen;

  typedef struct {
    int img; int w; int h; int sc;
    int exp_err; int exp_ow; int exp_oh; int exp_lat;
    int chk_idx; int chk_val;
  } vec_t;
  vec_t vecs[12];

  bilinear_seq_ctrl #(.AW(AW)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start(start),
    .cfg_in_w(cfg_in_w), .cfg_in_h(cfg_in_h), .cfg_scale_q88(cfg_scale_q88),
    .in_mem_raddr(in_mem_raddr), .in_mem_rdata(in_mem_rdata),
    .out_mem_waddr(out_mem_waddr), .out_mem_wdata(out_mem_wdata), .out_mem_we(out_mem_we),
    .busy(busy), .done(done), .cfg_err(cfg_err), .out_w(out_w), .out_h(out_h)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) in_mem_rdata <= in_img[in_mem_raddr];

  always @(posedge clk_sys) begin
    if (out_mem_we === 1'b1) begin
      wr_addr.push_back(int'(out_mem_waddr));
      wr_data.push_back(int'(out_mem_wdata));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_img(input int kind);
    for (int i = 0; i < MEMSZ; i++) begin
      case (kind)
        0:       in_img[i] = 8'(i);
        1:       in_img[i] = (i == 0) ? 8'd0 : (i == 3) ? 8'd200 : (i < 3) ? 8'd100 : 8'd0;
        2:       in_img[i] = (i >= 1 && i <= 3) ? 8'd1 : 8'd0;
        default: in_img[i] = 8'($urandom_range(255, 0));
      endcase
    end
  endtask

  function automatic void model_cfg(input int w, input int h, input int sc,
                                    output int err, output longint ow, output longint oh);
    ow  = (longint'(w) * sc) >> 8;
    oh  = (longint'(h) * sc) >> 8;
    err = (w == 0 || h == 0 || ow == 0 || oh == 0 || ow > 65535 || oh > 65535 ||
           longint'(w) * h > MEMSZ || ow * oh > MEMSZ) ? 1 : 0;
  endfunction

  // Output pixel idx: sample position is (ox*step, oy*step) in Q8.8, blended from four clamped neighbours.
  function automatic int model_pix(input int w, input int h, input int sc, input int idx);
    longint step, ow, ox, oy, sx, sy, x0, x1, y0, y1, fx, fy, top, bot, v;
    step = 65536 / sc;
    ow   = (longint'(w) * sc) >> 8;
    ox   = idx % ow;
    oy   = idx / ow;
    sx   = ox * step;
    sy   = oy * step;
    x0 = sx / 256; fx = sx % 256;
    y0 = sy / 256; fy = sy % 256;
    if (x0 >= w - 1) begin x0 = w - 1; x1 = x0; end else x1 = x0 + 1;
    if (y0 >= h - 1) begin y0 = h - 1; y1 = y0; end else y1 = y0 + 1;
    top = longint'(in_img[int'(y0 * w + x0)]) * (256 - fx) + longint'(in_img[int'(y0 * w + x1)]) * fx;
    bot = longint'(in_img[int'(y1 * w + x0)]) * (256 - fx) + longint'(in_img[int'(y1 * w + x1)]) * fx;
    v   = (top * (256 - fy) + bot * fy + RND) >> 16;
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic run_job(input int w, input int h, input int sc, input int plen, input int reedge,
                         output int lat);
    wr_addr.delete();
    wr_data.delete();
    @(posedge clk_sys); #1;
    cfg_in_w      = 16'(w);
    cfg_in_h      = 16'(h);
    cfg_scale_q88 = 16'(sc);
    start         = 1'b1;
    lat           = -1;
    busy_seen     = 1'b0;
    for (int n = 1; n <= 20000; n++) begin
      @(posedge clk_sys); #1;
      start = (n < plen) || (reedge != 0 && n == reedge);
      if (n == 1) busy_seen = busy;
      if (done === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL job_timeout: done never rose, got 0 expected 1");
    end
  endtask

  task automatic check_job(input string tag, input int w, input int h, input int sc,
                           input int exp_err, input int exp_ow, input int exp_oh,
                           input int exp_lat, input int lat);
    int nw;
    check({tag, " cfg_err"}, cfg_err, exp_err);
    check({tag, " out_w"}, out_w, exp_ow);
    check({tag, " out_h"}, out_h, exp_oh);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_during"}, busy_seen, 1);
    check({tag, " busy_after"}, busy, 0);
    nw = exp_err ? 0 : exp_ow * exp_oh;
    check({tag, " writes"}, wr_addr.size(), nw);
    for (int k = 0; k < wr_addr.size() && k < nw; k++) begin
      check($sformatf("%s waddr[%0d]", tag, k), wr_addr[k], k);
      check($sformatf("%s wdata[%0d]", tag, k), wr_data[k], model_pix(w, h, sc, k));
    end
  endtask

  initial begin
    int     lat, err, base;
    longint ow, oh;
    int     w, h, sc;

    rst_sys_n = 1'b0;
    start = 1'b0;
    cfg_in_w = '0; cfg_in_h = '0; cfg_scale_q88 = '0;
    fill_img(0);
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset raddr", in_mem_raddr, 0);
    check("reset we", out_mem_we, 0);
    check("reset busy_done_err", {busy, done, cfg_err}, 0);
    check("reset out_wh", {out_w, out_h}, 0);
    check("reset waddr_wdata", {out_mem_waddr, out_mem_wdata}, 0);
    rst_sys_n = 1'b1;

    vecs[0]  = '{0, 4, 4, 256, 0, 4, 4, 131, 5, 5};
    vecs[1]  = '{1, 2, 2, 512, 0, 4, 4, 131, 1, 50};
    vecs[2]  = '{1, 2, 2, 512, 0, 4, 4, 131, 5, 100};
    vecs[3]  = '{1, 2, 2, 512, 0, 4, 4, 131, 15, 200};
    vecs[4]  = '{2, 2, 2, 512, 0, 4, 4, 131, 1, RND_OUT1};
    vecs[5]  = '{0, 0, 4, 256, 1, 0, 4, 2, -1, 0};
    vecs[6]  = '{0, 64, 64, 256, 1, 64, 64, 2, -1, 0};
    vecs[7]  = '{0, 4, 4, 0, 1, 0, 0, 2, -1, 0};
    vecs[8]  = '{0, 32, 32, 256, 0, 32, 32, 7187, 1023, 255};
    vecs[9]  = '{0, 17, 16, 512, 1, 34, 32, 2, -1, 0};
    vecs[10] = '{0, 8, 8, 128, 0, 4, 4, 131, 5, 18};
    vecs[11] = '{3, 5, 3, 300, 0, 5, 3, 124, -1, 0};

    foreach (vecs[i]) begin
      fill_img(vecs[i].img);
      run_job(vecs[i].w, vecs[i].h, vecs[i].sc, 1, 0, lat);
      check_job($sformatf("vec%0d", i), vecs[i].w, vecs[i].h, vecs[i].sc,
                vecs[i].exp_err, vecs[i].exp_ow, vecs[i].exp_oh, vecs[i].exp_lat, lat);
      if (vecs[i].chk_idx >= 0)
        check($sformatf("vec%0d out[%0d]", i, vecs[i].chk_idx),
              (wr_data.size() > vecs[i].chk_idx) ? wr_data[vecs[i].chk_idx] : -1, vecs[i].chk_val);
    end

    // Long start pulse plus a second edge while busy: one job only.
    fill_img(0);
    run_job(4, 4, 256, 8, 40, lat);
    check_job("filter", 4, 4, 256, 0, 4, 4, 131, lat);
    repeat (40) @(posedge clk_sys);
    #1;
    check("filter writes_after", wr_addr.size(), 16);
    check("filter idle_busy", busy, 0);

    // Reset in the middle of FETCH, then stay quiet without a new start.
    wr_addr.delete();
    wr_data.delete();
    @(posedge clk_sys); #1;
    cfg_in_w = 16'd4; cfg_in_h = 16'd4; cfg_scale_q88 = 16'd256;
    start = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk_sys); #1;
      start = 1'b0;
    end
    check("midrst pre_busy", busy, 1);
    check("midrst pre_raddr", in_mem_raddr, 4);
    rst_sys_n = 1'b0;
    #1;
    check("midrst raddr", in_mem_raddr, 0);
    check("midrst we", out_mem_we, 0);
    check("midrst busy_done_err", {busy, done, cfg_err}, 0);
    check("midrst out_wh", {out_w, out_h}, 0);
    check("midrst waddr_wdata", {out_mem_waddr, out_mem_wdata}, 0);
    repeat (2) @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b1;
    base = wr_addr.size();
    repeat (200) @(posedge clk_sys);
    #1;
    check("midrst writes_after", wr_addr.size(), base);
    check("midrst idle_done", {busy, done}, 0);

    for (int r = 0; r < 8; r++) begin
      w  = $urandom_range(12, 1);
      h  = $urandom_range(12, 1);
      sc = $urandom_range(512, 32);
      fill_img(3);
      model_cfg(w, h, sc, err, ow, oh);
      run_job(w, h, sc, 1, 0, lat);
      check_job($sformatf("rnd%0d(%0dx%0d,s%0d)", r, w, h, sc), w, h, sc, err,
                int'(ow & 65535), int'(oh & 65535), err ? 2 : int'(19 + 7 * ow * oh), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bilinear_seq_ctrl.md
BILINEAR_SEQ_CTRL -- requirements
Module: bilinear_seq_ctrl

Interface
REQ-001 Parameter AW, default 12, is the address width of both the input and output pixel BRAMs.
REQ-002 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 rst_sys_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level request; only a rising edge is acted on, and pulses of 8 or more cycles count once.
REQ-005 cfg_in_w, cfg_in_h  input  16 each  input image width and height in pixels.
REQ-006 cfg_scale_q88  input  16  scale factor, unsigned Q8.8.
REQ-007 in_mem_raddr  output  AW  input BRAM read address; in_mem_rdata input 8 returns the pixel with 1-cycle latency.
REQ-008 out_mem_waddr output AW, out_mem_wdata output 8, out_mem_we output 1  output BRAM write port.
REQ-009 busy output 1; done output 1 (sticky); cfg_err output 1 (sticky); out_w, out_h output 16 each, the latched output dimensions.

Function
REQ-010 The block SHALL use a state machine with states IDLE, CHECK, DIV, FETCH, INTERP, WRITE, FIN and ERR.
REQ-011 In IDLE, a start rising edge (start=1 with the start_d register=0) SHALL perform all of the following in one cycle:
- latch the three configuration inputs;
- clear done and cfg_err;
- set busy;
- go to CHECK.
REQ-012 A start edge outside IDLE SHALL be ignored.
REQ-013 CHECK SHALL compute out_w=(in_w*scale)>>8 and out_h=(in_h*scale)>>8 at 32-bit width and register them.
REQ-014 CHECK SHALL go to ERR if any of the following holds; otherwise it goes to DIV:
- in_w=0 or in_h=0;
- out_w=0 or out_h=0;
- out_w>65535 or out_h>65535;
- in_w*in_h>2^AW;
- out_w*out_h>2^AW.
REQ-015 DIV SHALL run a restoring divider for exactly 17 cycles, producing step=floor(65536/scale) as a 17-bit value.
REQ-016 Pixel order SHALL be raster order (ox fastest), using 32-bit Q8.8 accumulators:
- sx resets to 0 at each row start and gains step after each pixel;
- sy resets to 0 at the job start and gains step after each row.
REQ-017 The sample coordinates SHALL be x0=sx>>8 and fx=sx[7:0], and likewise y0=sy>>8 and fy=sy[7:0].
REQ-018 If x0>=in_w-1, then x0=x1=in_w-1; otherwise x1=x0+1. The same rule SHALL apply to y0 and y1.
REQ-019 FETCH SHALL last 5 cycles per pixel:
- cycles 0-3 drive raddr = y0*in_w+x0, y0*in_w+x1, y1*in_w+x0, y1*in_w+x1;
- cycles 1-4 capture p00, p01, p10, p11.
REQ-020 INTERP SHALL last 1 cycle:
- top=p00*(256-fx)+p01*fx and bot=p10*(256-fx)+p11*fx, each 17 bits;
- pix=(top*(256-fy)+bot*fy+R)>>16, saturated to 255.
REQ-021 WRITE SHALL last 1 cycle and assert out_mem_we=1 with waddr equal to the linear output index, which starts at 0 and increments per write.
REQ-022 Each pixel SHALL take exactly 7 cycles.
REQ-023 After the last pixel the block SHALL enter FIN; done rises 19+7*out_w*out_h cycles after the start-edge cycle.
REQ-024 FIN SHALL clear busy, set done and return to IDLE.
REQ-025 ERR SHALL clear busy, set done and cfg_err, issue no writes and return to IDLE; done rises 2 cycles after the start edge.
REQ-026 out_mem_we SHALL be 0 in every state other than WRITE.

Reset
REQ-027 On reset assertion the block SHALL, asynchronously:
- go to IDLE;
- force busy, done, cfg_err, out_mem_we and start_d to 0;
- force in_mem_raddr, out_mem_waddr, out_mem_wdata, out_w and out_h to 0.
REQ-028 A reset mid-job SHALL abort the job with no further writes; a new start edge is required after release.

Configuration
REQ-029 The macro BILSEQ_ROUND_EN SHALL select the rounding term R in INTERP:
- defined: R=32768 (round half-up);
- undefined: R=0 (truncate).

Verification
REQ-030 Reset: assert rst_sys_n=0 mid-FETCH -> all outputs are 0 within the same cycle, and there are no writes after release until a new start.
REQ-031 Identity case: in 4x4 ramp (pixel=index), scale=256 -> out_w=out_h=4, 16 writes with data equal to the index, done 131 cycles after the edge.
REQ-032 2x upscale: in 2x2 {0,100,100,200}, scale=512 -> out 4x4 with:
- out[1]=50;
- out[5]=100;
- out[15]=200.
REQ-033 Config error: in_w=0 (or in 64x64 with AW=10) -> cfg_err=1 and done=1 two cycles after the edge, with zero writes.
REQ-034 Start filtering: an 8-cycle start pulse gives one job; a start edge while busy is ignored and the write count is unchanged.
REQ-035 Rounding: in 2x2 {0,1,1,1}, scale=512 -> out[1]=1 with BILSEQ_ROUND_EN defined, and 0 without it.
